lock_key_loader: RTL and testbench

- Upstream stage of the key-locked c432 netlist: it delivers the 19 key bits (mux key p1..p4 and XOR key X_1..X_15) to the locked combinational core.
- Receives the key as a bit-serial stream with valid/ready handshake, plus one trailing even-parity bit.
- Checks parity, then presents the key as a stable parallel word with key_valid.
- Holds the key at all-zero whenever no verified key is loaded.

---
 rtl/lock_key_pkg.sv | 36 +++
 rtl/lock_key_loader.sv | 122 ++++++++++++
 tb/tb_lock_key_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lock_key_pkg.sv
// Shared constants and state encoding for the c432 key loader and its netlist wrapper.
package lock_key_pkg;

  localparam int unsigned KEY_W = 19;
  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_PAR   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Key bit positions inside key_out: mux key p1..p4, then XOR key X_1..X_15.
  localparam int unsigned P1_IDX  = 18;
  localparam int unsigned P2_IDX  = 17;
  localparam int unsigned P3_IDX  = 16;
  localparam int unsigned P4_IDX  = 15;
  localparam int unsigned X1_IDX  = 14;
  localparam int unsigned X2_IDX  = 13;
  localparam int unsigned X3_IDX  = 12;
  localparam int unsigned X4_IDX  = 11;
  localparam int unsigned X5_IDX  = 10;
  localparam int unsigned X6_IDX  = 9;
  localparam int unsigned X7_IDX  = 8;
  localparam int unsigned X8_IDX  = 7;
  localparam int unsigned X9_IDX  = 6;
  localparam int unsigned X10_IDX = 5;
  localparam int unsigned X11_IDX = 4;
  localparam int unsigned X12_IDX = 3;
  localparam int unsigned X13_IDX = 2;
  localparam int unsigned X14_IDX = 1;
  localparam int unsigned X15_IDX = 0;

endpackage

// File: rtl/lock_key_loader.sv
// Serial-to-parallel key loader: shifts in KEY_W key bits MSB-first plus one even-parity
// bit, and presents the key with key_valid only after the parity check passes.
module lock_key_loader
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             ser_data,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   shreg_q, shreg_d;
  logic               par_q, par_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic               key_valid_q, key_valid_d;
  logic               key_err_q, key_err_d;
  logic               ser_ready_q, ser_ready_d;
  logic               busy_q, busy_d;
  logic               accept;

  assign accept = ser_valid & ser_ready_q;

  // Next-state and next-output logic; starting a load always wipes the previous key first.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
    key_err_d   = key_err_q;

    if (load_start) begin
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      shreg_d     = '0;
      par_d       = 1'b0;
      key_out_d   = '0;
      key_valid_d = 1'b0;
      key_err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (accept) begin
            shreg_d = {shreg_q[KEY_W-2:0], ser_data};
            cnt_d   = cnt_q + CNT_W'(1);
            par_d   = par_q ^ ser_data;
            if (cnt_q == CNT_W'(KEY_W - 1)) begin
              state_d = ST_PAR;
            end
          end
        end
        ST_PAR: begin
          if (accept) begin
            if (par_q ^ ser_data) begin
              state_d     = ST_ERR;
              key_out_d   = '0;
              key_valid_d = 1'b0;
              key_err_d   = 1'b1;
            end else begin
              state_d     = ST_DONE;
              key_out_d   = shreg_q;
              key_valid_d = 1'b1;
              key_err_d   = 1'b0;
            end
          end
        end
        ST_IDLE, ST_DONE, ST_ERR: begin
          state_d = state_q;
        end
        default: begin
          state_d     = ST_IDLE;
          key_out_d   = '0;
          key_valid_d = 1'b0;
        end
      endcase
    end

    // Handshake flags follow the state being entered so they stay registered.
    ser_ready_d = (state_d == ST_SHIFT) || (state_d == ST_PAR);
    busy_d      = ser_ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      ser_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      ser_ready_q <= ser_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_ready = ser_ready_q;
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: a table of full loads plus hand-written
// sequences for reset, restart, stalls and post-DONE behaviour.
module tb_lock_key_loader;
  import lock_key_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_start;
  logic             ser_data;
  logic             ser_valid;
  logic             ser_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             key_err;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  lock_key_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .key_err    (key_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] key;
    logic        par;
    logic [18:0] exp_key;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    ser_data  = b;
    tick();
    ser_valid = 1'b0;
  endtask

  // Send key MSB-first then the parity bit; with toggle, an idle cycle carrying a
  // decoy bit precedes every real bit.
  task automatic send_key(input logic [18:0] key, input logic par, input bit toggle,
                          output int cycles);
    cycles = 0;
    for (int i = 18; i >= 0; i--) begin
      if (toggle) begin
        ser_valid = 1'b0;
        ser_data  = ~key[i];
        tick();
        cycles++;
      end
      send_bit(key[i]);
      cycles++;
    end
    if (toggle) begin
      ser_valid = 1'b0;
      ser_data  = ~par;
      tick();
      cycles++;
    end
    send_bit(par);
    cycles++;
  endtask

  task automatic chk_outs(input string tag, input logic [18:0] k, input logic v,
                          input logic e, input logic b);
    chk({tag, ".key_out"},   32'(key_out),   32'(k));
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(v));
    chk({tag, ".key_err"},   32'(key_err),   32'(e));
    chk({tag, ".busy"},      32'(busy),      32'(b));
    chk({tag, ".ser_ready"}, 32'(ser_ready), 32'(b));
  endtask

  initial begin
    int cyc;
    logic [3:0] pbits;

    vecs[0] = '{19'h5A3C7, 1'b1, 19'h5A3C7, 1'b1, 1'b0};
    vecs[1] = '{19'h5A3C7, 1'b0, 19'h00000, 1'b0, 1'b1};
    vecs[2] = '{19'h00001, 1'b1, 19'h00001, 1'b1, 1'b0};
    vecs[3] = '{19'h7FFFF, 1'b1, 19'h7FFFF, 1'b1, 1'b0};
    vecs[4] = '{19'h7FFFF, 1'b0, 19'h00000, 1'b0, 1'b1};
    vecs[5] = '{19'h00000, 1'b0, 19'h00000, 1'b1, 1'b0};
    vecs[6] = '{19'h12345, 1'b1, 19'h12345, 1'b1, 1'b0};
    vecs[7] = '{19'h40000, 1'b0, 19'h00000, 1'b0, 1'b1};

    rst_n      = 1'b0;
    load_start = 1'b0;
    ser_data   = 1'b0;
    ser_valid  = 1'b0;
    tick();
    tick();
    chk_outs("reset", 19'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Bits offered while idle are ignored.
    send_bit(1'b1);
    chk_outs("idle_valid", 19'h0, 1'b0, 1'b0, 1'b0);

    // Async reset mid-SHIFT after 7 bits.
    start();
    chk_outs("shift_entry", 19'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 19'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    start();
    send_key(19'h5A3C7, 1'b1, 1'b0, cyc);
    chk_outs("after_rst_load", 19'h5A3C7, 1'b1, 1'b0, 1'b0);

    // Table of full loads.
    foreach (vecs[i]) begin
      start();
      chk({$sformatf("vec%0d.cleared_key", i)},  32'(key_out),   32'h0);
      chk({$sformatf("vec%0d.cleared_err", i)},  32'(key_err),   32'h0);
      send_key(vecs[i].key, vecs[i].par, 1'b0, cyc);
      chk($sformatf("vec%0d.key_out", i),   32'(key_out),   32'(vecs[i].exp_key));
      chk($sformatf("vec%0d.key_valid", i), 32'(key_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.key_err", i),   32'(key_err),   32'(vecs[i].exp_err));
      chk($sformatf("vec%0d.busy", i),      32'(busy),      32'h0);
    end

    // Latency: nothing is published until the parity bit is accepted.
    start();
    for (int i = 18; i >= 0; i--) send_bit(vecs[0].key[i]);
    chk_outs("in_par", 19'h0, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    chk_outs("par_accepted", 19'h5A3C7, 1'b1, 1'b0, 1'b0);
    pbits = key_out[P1_IDX:P4_IDX];
    chk("p1_p4", 32'(pbits), 32'hB);

    // Bad parity followed by a restart clears the sticky error.
    start();
    send_key(19'h5A3C7, 1'b0, 1'b0, cyc);
    chk_outs("bad_par", 19'h0, 1'b0, 1'b1, 1'b0);
    start();
    chk_outs("err_cleared", 19'h0, 1'b0, 1'b0, 1'b1);

    // Stalled load with ser_valid toggling every cycle.
    send_key(19'h5A3C7, 1'b1, 1'b1, cyc);
    chk("toggle.cycles", 32'(cyc), 32'd40);
    chk_outs("toggle", 19'h5A3C7, 1'b1, 1'b0, 1'b0);

    // Restart after 10 bits; the partial load leaves no trace.
    start();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    start();
    send_key(19'h00001, 1'b1, 1'b0, cyc);
    chk_outs("restart", 19'h00001, 1'b1, 1'b0, 1'b0);

    // Restart while in PAR with a bit presented in the same cycle: the bit is dropped.
    start();
    for (int i = 18; i >= 0; i--) send_bit(1'b1);
    load_start = 1'b1;
    send_bit(1'b1);
    load_start = 1'b0;
    chk_outs("par_restart", 19'h0, 1'b0, 1'b0, 1'b1);
    send_key(19'h12345, 1'b1, 1'b0, cyc);
    chk_outs("par_restart_load", 19'h12345, 1'b1, 1'b0, 1'b0);

    // All-ones key, extra bits after DONE are refused, then reload clears the key.
    start();
    send_key(19'h7FFFF, 1'b1, 1'b0, cyc);
    chk_outs("ones", 19'h7FFFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0);
      chk_outs($sformatf("post_done%0d", i), 19'h7FFFF, 1'b1, 1'b0, 1'b0);
    end
    start();
    chk_outs("reload_clear", 19'h0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
